rf_wport_arbiter: RTL and testbench



---
 rtl/rf_wport_arbiter.sv | 110 +++++++++++
 tb/tb_rf_wport_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// Purpose : shares the single register-file write port between the main write-back (A) and the
//           long-latency mul/div/CP0 completion path (B), with starvation protection for B.
// Latency : 1 cycle from grant (valid && ready) to rf_we/rf_waddr/rf_wdata/wsel.
// Backpr. : a_ready/b_ready are combinational grants, at most one high per cycle; the RF never stalls.
// Ports   : clk, rst_n (async active-low); a_valid/a_ready/a_addr/a_data and b_valid/b_ready/b_addr/b_data
//           requesters; rf_we/rf_waddr/rf_wdata registered RF write; wsel registered address-mux select
//           (0 = A, 1 = B); starved registered force-grant indicator.
module rf_wport_arbiter #(
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          wsel,
  output logic          starved
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  // Source of the write captured at the last edge.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_A    = 2'd1,
    S_B    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    starve_cnt_q, starve_cnt_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wsel_q, wsel_d;
  logic          starved_q;
  logic          grant_a, grant_b;

  // B wins when it is being force-granted, when it collides with A on the same
  // destination (B is the older result, A overwrites it next cycle), or when A is idle.
  always_comb begin
    grant_b = b_valid && ((starve_cnt_q == SMAX) ||
                          (a_valid && (a_addr == b_addr)) ||
                          !a_valid);
    grant_a = a_valid && !grant_b;
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!b_valid || grant_b) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q < SMAX) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    state_d = S_IDLE;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wsel_d  = wsel_q;
    if (grant_b) begin
      state_d = S_B;
      waddr_d = b_addr;
      wdata_d = b_data;
      wsel_d  = 1'b1;
    end else if (grant_a) begin
      state_d = S_A;
      waddr_d = a_addr;
      wdata_d = a_data;
      wsel_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      starve_cnt_q <= 4'd0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      wsel_q       <= 1'b0;
      starved_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      wsel_q       <= wsel_d;
      starved_q    <= (starve_cnt_d == SMAX);
    end
  end

  // A write happened last cycle unless it targeted r0, which is accepted but
  // never written. Built from registers only, so it clears with reset at once.
  assign rf_we    = (state_q != S_IDLE) && (waddr_q != '0);
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign wsel     = wsel_q;
  assign starved  = starved_q;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter with hand-computed expectations.
module tb_rf_wport_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        rf_we, wsel, starved;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int errors = 0;
  int checks = 0;

  rf_wport_arbiter #(.AW(5), .DW(32), .STARVE_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wsel(wsel), .starved(starved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    checks++; if (rf_we !== 1'b0)     begin errors++; $display("FAIL reset_we got %b exp 0", rf_we); end
    checks++; if (rf_waddr !== 5'd0)  begin errors++; $display("FAIL reset_waddr got %0d exp 0", rf_waddr); end
    checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h exp 0", rf_wdata); end
    checks++; if (wsel !== 1'b0)      begin errors++; $display("FAIL reset_wsel got %b exp 0", wsel); end
    checks++; if (starved !== 1'b0)   begin errors++; $display("FAIL reset_starved got %b exp 0", starved); end
    rst_n = 1'b1;
    tick();
    // Get a B write onto the port, then reset mid-cycle.
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h55;
    tick();
    checks++; if (rf_we !== 1'b1 || wsel !== 1'b1) begin errors++; $display("FAIL pre_reset_write got we=%b wsel=%b exp we=1 wsel=1", rf_we, wsel); end
    a_valid = 1'b1; a_addr = 5'd6;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b0)    begin errors++; $display("FAIL async_reset_we got %b exp 0", rf_we); end
    checks++; if (wsel !== 1'b0)     begin errors++; $display("FAIL async_reset_wsel got %b exp 0", wsel); end
    checks++; if (starved !== 1'b0)  begin errors++; $display("FAIL async_reset_starved got %b exp 0", starved); end
    checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL async_reset_waddr got %0d exp 0", rf_waddr); end
    idle_inputs();
    #2;
    rst_n = 1'b1;
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL post_reset_a_ready got %b exp 1", a_ready); end
    checks++; if (rf_we !== 1'b0)   begin errors++; $display("FAIL post_reset_we_early got %b exp 0", rf_we); end
    tick();
    idle_inputs();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h77)
      begin errors++; $display("FAIL post_reset_first_write got we=%b addr=%0d data=%h exp we=1 addr=7 data=77", rf_we, rf_waddr, rf_wdata); end
    tick();
  endtask

  task automatic test_a_only();
    a_valid = 1'b1; a_addr = 5'd8; a_data = 32'h1234_5678;
    #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("FAIL a_only_ready got a=%b b=%b exp a=1 b=0", a_ready, b_ready); end
    tick();
    idle_inputs();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h1234_5678 || wsel !== 1'b0)
      begin errors++; $display("FAIL a_only_write got we=%b addr=%0d data=%h wsel=%b exp 1/8/12345678/0", rf_we, rf_waddr, rf_wdata, wsel); end
    tick();
    checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd8 || rf_wdata !== 32'h1234_5678)
      begin errors++; $display("FAIL a_only_hold got we=%b addr=%0d data=%h exp 0/8/12345678", rf_we, rf_waddr, rf_wdata); end
  endtask

  task automatic test_starvation();
    logic exp_b;
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hAAAA;
    b_valid = 1'b1; b_addr = 5'd5; b_data = 32'hBBBB;
    for (int c = 0; c < 12; c++) begin
      exp_b = ((c % 4) == 3);
      #1;
      checks++; if (a_ready !== !exp_b || b_ready !== exp_b)
        begin errors++; $display("FAIL starve_ready c=%0d got a=%b b=%b exp a=%b b=%b", c, a_ready, b_ready, !exp_b, exp_b); end
      tick();
      checks++; if (wsel !== exp_b || rf_waddr !== (exp_b ? 5'd5 : 5'd3) || rf_we !== 1'b1)
        begin errors++; $display("FAIL starve_write c=%0d got wsel=%b addr=%0d we=%b exp wsel=%b", c, wsel, rf_waddr, rf_we, exp_b); end
      checks++; if (starved !== ((c % 4) == 2))
        begin errors++; $display("FAIL starve_flag c=%0d got %b exp %b", c, starved, ((c % 4) == 2)); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_collision();
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'hA;
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'hB;
    #1;
    checks++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin errors++; $display("FAIL collide_ready got a=%b b=%b exp a=0 b=1", a_ready, b_ready); end
    tick();
    b_valid = 1'b0;
    checks++; if (rf_we !== 1'b1 || rf_wdata !== 32'hB || wsel !== 1'b1)
      begin errors++; $display("FAIL collide_first got we=%b data=%h wsel=%b exp 1/b/1", rf_we, rf_wdata, wsel); end
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL collide_a_ready got %b exp 1", a_ready); end
    tick();
    idle_inputs();
    checks++; if (rf_we !== 1'b1 || rf_wdata !== 32'hA || wsel !== 1'b0 || rf_waddr !== 5'd9)
      begin errors++; $display("FAIL collide_second got we=%b data=%h wsel=%b addr=%0d exp 1/a/0/9", rf_we, rf_wdata, wsel, rf_waddr); end
    tick();
  endtask

  task automatic test_zero_reg();
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFF_FFFF;
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL zero_b_ready got %b exp 1", b_ready); end
    tick();
    idle_inputs();
    checks++; if (rf_we !== 1'b0 || wsel !== 1'b1 || rf_waddr !== 5'd0 || rf_wdata !== 32'hFFFF_FFFF)
      begin errors++; $display("FAIL zero_write got we=%b wsel=%b addr=%0d data=%h exp 0/1/0/ffffffff", rf_we, wsel, rf_waddr, rf_wdata); end
    tick();
  endtask

  task automatic test_b_drop();
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h3;
    b_addr = 5'd5; b_data = 32'h5;
    b_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL drop_refused c=%0d got %b exp 0", c, b_ready); end
      tick();
    end
    b_valid = 1'b0;
    tick();
    checks++; if (starved !== 1'b0) begin errors++; $display("FAIL drop_starved_clear got %b exp 0", starved); end
    b_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL drop_restart c=%0d got %b exp 0", c, b_ready); end
      tick();
    end
    checks++; if (starved !== 1'b1) begin errors++; $display("FAIL drop_starved_set got %b exp 1", starved); end
    #1;
    checks++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin errors++; $display("FAIL drop_force_grant got a=%b b=%b exp a=0 b=1", a_ready, b_ready); end
    tick();
    idle_inputs();
    checks++; if (wsel !== 1'b1 || rf_waddr !== 5'd5 || starved !== 1'b0)
      begin errors++; $display("FAIL drop_force_write got wsel=%b addr=%0d starved=%b exp 1/5/0", wsel, rf_waddr, starved); end
    tick();
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_starvation();
    test_collision();
    test_zero_reg();
    test_b_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
